// File: rtl/vrtop_bist_pkg.sv
// Shared types and constants for the BIST sequencer: FSM states, cluster mode codes,
// LFSR tap mask and the per-state control decode.
package vrtop_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CAPTURE,
        WAIT,
        UNLOAD,
        READ,
        DONE
    } state_t;

    localparam logic [1:0] SE_CAP   = 2'b00;
    localparam logic [1:0] SE_SHIFT = 2'b01;
    localparam logic [1:0] SE_READ  = 2'b10;

    // Fibonacci taps 16,14,13,11 expressed as a bit mask over a 16-bit register
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       cs;
        logic       trg;
        logic [1:0] se;
        logic       lck;
        logic [1:0] scj;
        logic       sge;
        logic       sci;
    } ctrl_t;

    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Control word seen by the datapath while the FSM sits in state s
    function automatic ctrl_t ctrlFor(input state_t s, input logic [1:0] scj,
                                      input logic sge, input logic sci);
        ctrl_t c;
        c = '0;
        case (s)
            SHIFT: begin
                c.busy = 1'b1;
                c.cs   = 1'b1;
                c.se   = SE_SHIFT;
                c.lck  = 1'b1;
                c.scj  = scj;
                c.sge  = sge;
                c.sci  = sci;
            end
            CAPTURE: begin
                c.busy = 1'b1;
                c.trg  = 1'b1;
                c.se   = SE_CAP;
                c.lck  = 1'b1;
            end
            WAIT: begin
                c.busy = 1'b1;
                c.se   = SE_CAP;
                c.lck  = 1'b1;
            end
            UNLOAD: begin
                c.busy = 1'b1;
                c.cs   = 1'b1;
                c.se   = SE_SHIFT;
                c.lck  = 1'b1;
                c.scj  = 2'b11;
                c.sge  = 1'b1;
            end
            READ: begin
                c.busy = 1'b1;
                c.cs   = 1'b1;
                c.se   = SE_READ;
                c.scj  = 2'b11;
            end
            DONE: begin
                c.done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vrtop_bist_ctrl_lfsr.sv
// Pattern LFSR: loads a seed, advances one Fibonacci step per enabled cycle and
// exposes both its current MSB and the MSB it will have after the next step.
module bist_lfsr
    import vrtop_bist_pkg::*;
#(
    parameter int LFSR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_enable,
    input  logic [LFSR_W-1:0] i_seed,
    output logic              o_msb,
    output logic              o_nextMsb
);

    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(LFSR_TAPS);

    logic [LFSR_W-1:0] r_lfsr;
    logic              w_feedback;

    assign w_feedback = ^(r_lfsr & TAPS);
    assign o_msb      = r_lfsr[LFSR_W-1];
    assign o_nextMsb  = r_lfsr[LFSR_W-2];

    always_ff @(posedge clk) begin
        if (reset || i_load) begin
            r_lfsr <= i_seed;
        end else if (i_enable) begin
            r_lfsr <= {r_lfsr[LFSR_W-2:0], w_feedback};
        end
    end

endmodule

// File: rtl/vrtop_bist_ctrl.sv
// BIST sequencer: shifts LFSR patterns, captures and compacts NUM_PATTERNS responses,
// then reads the signature back serially from sg0 and compares it with expected_sig.
module vrtop_bist_ctrl
    import vrtop_bist_pkg::*;
#(
    parameter int              SHIFT_LEN    = 16,
    parameter int              NUM_PATTERNS = 8,
    parameter int              CAP_WAIT     = 2,
    parameter int              SIG_W        = 16,
    parameter int              LFSR_W       = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SIG_W-1:0] expected_sig,
    input  logic             sg0,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             cs,
    output logic             trg,
    output logic             se0,
    output logic             se1,
    output logic             lck,
    output logic             scj0,
    output logic             scj1,
    output logic             sge,
    output logic             sci
);

    localparam int CNT_MAX = maxOf3(SHIFT_LEN, CAP_WAIT, SIG_W);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PC_W    = $clog2(NUM_PATTERNS + 1);

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_LEN - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(CAP_WAIT - 1);
    localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(SIG_W - 1);
    localparam logic [PC_W-1:0]  PC_END     = PC_W'(NUM_PATTERNS);

    state_t           r_state;
    ctrl_t            r_ctrl;
    logic             r_pass;
    logic [CNT_W-1:0] r_cnt;
    logic [PC_W-1:0]  r_pc;
    logic [SIG_W-1:0] r_expected;
    logic [SIG_W-1:0] r_sigCap;

    logic             w_lfsrLoad;
    logic             w_lfsrAdv;
    logic             w_lfsrMsb;
    logic             w_lfsrNextMsb;
    logic [PC_W-1:0]  w_pcInc;
    logic [SIG_W-1:0] w_sigNext;

    assign w_lfsrLoad = (r_state == IDLE) && start;
    assign w_lfsrAdv  = (r_state == SHIFT);
    assign w_pcInc    = r_pc + PC_W'(1);
    assign w_sigNext  = {r_sigCap[SIG_W-2:0], sg0};

    bist_lfsr #(
        .LFSR_W (LFSR_W)
    ) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_lfsrLoad),
        .i_enable  (w_lfsrAdv),
        .i_seed    (LFSR_SEED),
        .o_msb     (w_lfsrMsb),
        .o_nextMsb (w_lfsrNextMsb)
    );

    // Outputs are registered from the state being entered, so they line up with r_state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ctrl     <= '0;
            r_pass     <= 1'b0;
            r_cnt      <= '0;
            r_pc       <= '0;
            r_expected <= '0;
            r_sigCap   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ctrl <= '0;
                    if (start) begin
                        r_state    <= SHIFT;
                        r_cnt      <= SHIFT_LAST;
                        r_pc       <= '0;
                        r_expected <= expected_sig;
                        r_pass     <= 1'b0;
                        r_ctrl     <= ctrlFor(SHIFT, 2'b00, 1'b0, LFSR_SEED[LFSR_W-1]);
                    end
                end
                SHIFT: begin
                    if (r_cnt == '0) begin
                        r_state <= CAPTURE;
                        r_ctrl  <= ctrlFor(CAPTURE, 2'b00, 1'b0, 1'b0);
                    end else begin
                        r_cnt  <= r_cnt - CNT_W'(1);
                        r_ctrl <= ctrlFor(SHIFT, 2'(r_pc), r_pc != '0, w_lfsrNextMsb);
                    end
                end
                CAPTURE: begin
                    r_state <= WAIT;
                    r_cnt   <= WAIT_LAST;
                    r_ctrl  <= ctrlFor(WAIT, 2'b00, 1'b0, 1'b0);
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_pc  <= w_pcInc;
                        r_cnt <= SHIFT_LAST;
                        if (w_pcInc == PC_END) begin
                            r_state <= UNLOAD;
                            r_ctrl  <= ctrlFor(UNLOAD, 2'b11, 1'b1, 1'b0);
                        end else begin
                            r_state <= SHIFT;
                            r_ctrl  <= ctrlFor(SHIFT, 2'(w_pcInc), w_pcInc != '0, w_lfsrMsb);
                        end
                    end else begin
                        r_cnt  <= r_cnt - CNT_W'(1);
                        r_ctrl <= ctrlFor(WAIT, 2'b00, 1'b0, 1'b0);
                    end
                end
                UNLOAD: begin
                    if (r_cnt == '0) begin
                        r_state <= READ;
                        r_cnt   <= READ_LAST;
                        r_ctrl  <= ctrlFor(READ, 2'b11, 1'b0, 1'b0);
                    end else begin
                        r_cnt  <= r_cnt - CNT_W'(1);
                        r_ctrl <= ctrlFor(UNLOAD, 2'b11, 1'b1, 1'b0);
                    end
                end
                READ: begin
                    r_sigCap <= w_sigNext;
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                        r_pass  <= (w_sigNext == r_expected);
                        r_ctrl  <= ctrlFor(DONE, 2'b00, 1'b0, 1'b0);
                    end else begin
                        r_cnt  <= r_cnt - CNT_W'(1);
                        r_ctrl <= ctrlFor(READ, 2'b11, 1'b0, 1'b0);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_ctrl  <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ctrl  <= '0;
                end
            endcase
        end
    end

    assign busy = r_ctrl.busy;
    assign done = r_ctrl.done;
    assign pass = r_pass;
    assign cs   = r_ctrl.cs;
    assign trg  = r_ctrl.trg;
    assign se1  = r_ctrl.se[1];
    assign se0  = r_ctrl.se[0];
    assign lck  = r_ctrl.lck;
    assign scj1 = r_ctrl.scj[1];
    assign scj0 = r_ctrl.scj[0];
    assign sge  = r_ctrl.sge;
    assign sci  = r_ctrl.sci;

endmodule

// File: tb/tb_vrtop_bist_ctrl.sv
// Self-checking bench for vrtop_bist_ctrl: two instances (2 patterns and 1 pattern) compared
// cycle by cycle against a timeline model derived from the run structure.
module tb_vrtop_bist_ctrl;

    localparam int          SL   = 16;
    localparam int          CW   = 2;
    localparam int          SW   = 16;
    localparam int          NPA  = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset;
    logic        start  [2];
    logic [15:0] expSig [2];
    logic        sg0    [2];
    logic        busy [2], done [2], pass [2], cs [2], trg [2], se0 [2], se1 [2];
    logic        lck  [2], scj0 [2], scj1 [2], sge [2], sci [2];

    int checks = 0;
    int errors = 0;
    logic msbTab [0:NPA*SL];

    always #5 clk = ~clk;

    vrtop_bist_ctrl #(
        .SHIFT_LEN(SL), .NUM_PATTERNS(2), .CAP_WAIT(CW), .SIG_W(SW), .LFSR_W(16), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .start(start[0]), .expected_sig(expSig[0]), .sg0(sg0[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .cs(cs[0]), .trg(trg[0]),
        .se0(se0[0]), .se1(se1[0]), .lck(lck[0]), .scj0(scj0[0]), .scj1(scj1[0]),
        .sge(sge[0]), .sci(sci[0])
    );

    vrtop_bist_ctrl #(
        .SHIFT_LEN(SL), .NUM_PATTERNS(1), .CAP_WAIT(CW), .SIG_W(SW), .LFSR_W(16), .LFSR_SEED(SEED)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .expected_sig(expSig[1]), .sg0(sg0[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .cs(cs[1]), .trg(trg[1]),
        .se0(se0[1]), .se1(se1[1]), .lck(lck[1]), .scj0(scj0[1]), .scj1(scj1[1]),
        .sge(sge[1]), .sci(sci[1])
    );

    // Packing: {busy,done,pass,cs,trg,se1,se0,lck,scj1,scj0,sge,sci}
    function automatic logic [11:0] obsOf(input int d);
        return {busy[d], done[d], pass[d], cs[d], trg[d], se1[d], se0[d],
                lck[d], scj1[d], scj0[d], sge[d], sci[d]};
    endfunction

    // Expected outputs t cycles after start acceptance, from the run timeline
    function automatic logic [11:0] expOut(input int np, input int t, input logic passExp);
        int period;
        int total;
        int p;
        int o;
        int u;
        logic bE, dE, pE, csE, tE, s1E, s0E, lE, sgE, sciE;
        logic [1:0] jE;
        period = SL + 1 + CW;
        total  = 1 + np * period + SL + SW;
        {bE, dE, pE, csE, tE, s1E, s0E, lE, sgE, sciE} = '0;
        jE = 2'b00;
        if (t == total) begin
            dE = 1'b1;
            pE = passExp;
        end else if (t > total) begin
            pE = passExp;
        end else if (t >= 1) begin
            bE = 1'b1;
            if (t - 1 < np * period) begin
                p = (t - 1) / period;
                o = (t - 1) % period;
                lE = 1'b1;
                if (o < SL) begin
                    csE  = 1'b1;
                    s0E  = 1'b1;
                    sgE  = (p > 0);
                    jE   = 2'(p);
                    sciE = msbTab[p * SL + o];
                end else if (o == SL) begin
                    tE = 1'b1;
                end
            end else begin
                u   = t - 1 - np * period;
                csE = 1'b1;
                jE  = 2'b11;
                if (u < SL) begin
                    s0E = 1'b1;
                    lE  = 1'b1;
                    sgE = 1'b1;
                end else begin
                    s1E = 1'b1;
                end
            end
        end
        return {bE, dE, pE, csE, tE, s1E, s0E, lE, jE, sgE, sciE};
    endfunction

    task automatic checkOutput(input int d, input string tag, input int t, input logic [11:0] expv);
        logic [11:0] obs;
        obs = obsOf(d);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, expv);
        end
    endtask

    // One run on instance d; optional mid-run reset at abortAt and ignored start pulses
    task automatic applyStimulus(input int d, input logic [15:0] expS, input logic [15:0] data,
                                 input int abortAt, input bit inject, input string tag);
        int   np;
        int   total;
        int   rd0;
        logic pe;
        np    = (d == 0) ? 2 : 1;
        total = 1 + np * (SL + 1 + CW) + SL + SW;
        rd0   = total - SW;
        pe    = (data == expS);
        start[d]  = 1'b1;
        expSig[d] = expS;
        for (int t = 1; t <= total; t++) begin
            @(negedge clk);
            start[d]  = inject && (t == 5 || t == total);
            expSig[d] = 16'($urandom);
            if (t >= rd0 && t < total) sg0[d] = data[SW - 1 - (t - rd0)];
            else                       sg0[d] = 1'($urandom);
            checkOutput(d, tag, t, expOut(np, t, pe));
            if (t == abortAt) begin
                reset = 1'b1;
                @(negedge clk);
                start[d] = 1'b0;
                checkOutput(d, {tag, "_rst"}, t + 1, 12'h000);
                reset = 1'b0;
                return;
            end
        end
        @(negedge clk);
        start[d] = 1'b0;
        checkOutput(d, {tag, "_idle"}, total + 1, expOut(np, total + 1, pe));
    endtask

    initial begin
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] q;
        l = SEED;
        for (int i = 0; i <= NPA * SL; i++) begin
            msbTab[i] = l[15];
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end

        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start[d]  = 1'b0;
            expSig[d] = 16'h0000;
            sg0[d]    = 1'b0;
        end
        repeat (3) @(negedge clk);
        checkOutput(0, "reset", 0, 12'h000);
        checkOutput(1, "reset1", 0, 12'h000);
        reset = 1'b0;
        @(negedge clk);
        checkOutput(0, "idle", 0, 12'h000);

        applyStimulus(0, 16'hBEEF, 16'hBEEF, 0, 1'b1, "run_pass");
        applyStimulus(0, 16'hBEEE, 16'hBEEF, 0, 1'b0, "run_fail");
        applyStimulus(0, 16'($urandom), 16'($urandom), 25, 1'b0, "run_abort");
        r = 16'($urandom);
        applyStimulus(0, r, r, 0, 1'b0, "run_after_rst");

        applyStimulus(1, 16'h1234, 16'h1234, 0, 1'b0, "np1_pass");
        for (int k = 0; k < 4; k++) begin
            r = 16'($urandom);
            q = (k % 2 == 0) ? r : (r ^ (16'h0001 << $urandom_range(15, 0)));
            applyStimulus(k % 2, r, q, 0, 1'b0, "rand_run");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
